// File: rtl/tap_tempo_meter.sv
// Tap tempo meter: turns a debounced tap pulse train into a clk_rx cycle count,
// averaged over the last four accepted intervals, for use as a step-rate reload.
module tap_tempo_meter #(
  parameter int CNT_W          = 24,
  parameter int DEBOUNCE       = 16,
  parameter int MIN_PERIOD     = 1000,
  parameter int MAX_PERIOD     = 12000000,
  parameter int DEFAULT_PERIOD = 6000000
) (
  input  logic             clk_rx,
  input  logic             nrst,
  input  logic             tap_in,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  output logic             locked,
  output logic             tap_seen
);

  // state | meaning
  // IDLE  | no reference tap; waiting for a first tap
  // FIRST | one tap seen, timing the interval to the next
  // TRACK | locked; each valid tap updates the 4-entry history
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FIRST = 2'd1,
    S_TRACK = 2'd2
  } state_t;

  localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0] DEF_C = CNT_W'(DEFAULT_PERIOD);
  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_filt;
  logic [DB_W-1:0]  r_db_cnt;
  logic             r_tap;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_hist [0:3];
  logic [CNT_W-1:0] r_period;
  logic             r_valid;
  state_t           r_state;

  state_t           w_state_nxt;
  logic             w_load_cnt;
  logic             w_accept;
  logic             w_fill;
  logic             w_clear;
  logic             w_in_range;
  logic             w_at_max;
  logic [CNT_W-1:0] w_hist_nxt [0:3];
  logic [CNT_W+1:0] w_sum;

  always_ff @(posedge clk_rx) begin
    if (!nrst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= tap_in;
      r_sync2 <= r_sync1;
    end
  end

  // Level is taken only after DEBOUNCE consecutive differing samples; any agreeing
  // sample restarts the count. The tap pulse is issued on the same edge the level flips.
  always_ff @(posedge clk_rx) begin
    if (!nrst) begin
      r_filt   <= 1'b0;
      r_db_cnt <= '0;
      r_tap    <= 1'b0;
    end else begin
      r_tap <= 1'b0;
      if (r_sync2 != r_filt) begin
        if (r_db_cnt == DB_LAST) begin
          r_filt   <= r_sync2;
          r_db_cnt <= '0;
          r_tap    <= r_sync2;
        end else begin
          r_db_cnt <= r_db_cnt + 1'b1;
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  assign w_in_range = (r_cnt >= MIN_C);
  assign w_at_max   = (r_cnt == MAX_C);

  always_ff @(posedge clk_rx) begin
    if (!nrst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Short taps leave the counter running so the next interval is measured
  // from the last accepted tap.
  always_comb begin
    w_state_nxt = r_state;
    w_load_cnt  = 1'b0;
    w_accept    = 1'b0;
    w_fill      = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_tap) begin
          w_state_nxt = S_FIRST;
          w_load_cnt  = 1'b1;
        end
      end
      S_FIRST: begin
        if (r_tap && w_in_range) begin
          w_state_nxt = S_TRACK;
          w_load_cnt  = 1'b1;
          w_accept    = 1'b1;
          w_fill      = 1'b1;
        end else if (!r_tap && w_at_max) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_TRACK: begin
        if (r_tap && w_in_range) begin
          w_load_cnt = 1'b1;
          w_accept   = 1'b1;
        end else if (!r_tap && w_at_max) begin
          w_state_nxt = S_IDLE;
          w_clear     = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_rx) begin
    if (!nrst) begin
      r_cnt <= '0;
    end else if (w_load_cnt) begin
      r_cnt <= CNT_W'(1);
    end else if (!w_at_max) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_hist_nxt = r_hist;
    if (w_fill) begin
      for (int i = 0; i < 4; i++) w_hist_nxt[i] = r_cnt;
    end else begin
      for (int i = 0; i < 3; i++) w_hist_nxt[i] = r_hist[i+1];
      w_hist_nxt[3] = r_cnt;
    end
    w_sum = '0;
    for (int i = 0; i < 4; i++) w_sum = w_sum + {2'b00, w_hist_nxt[i]};
  end

  // period_out is held through timeout; only reset restores the default.
  always_ff @(posedge clk_rx) begin
    if (!nrst) begin
      for (int i = 0; i < 4; i++) r_hist[i] <= '0;
      r_period <= DEF_C;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_accept) begin
        for (int i = 0; i < 4; i++) r_hist[i] <= w_hist_nxt[i];
        r_period <= CNT_W'(w_sum >> 2);
        r_valid  <= 1'b1;
      end else if (w_clear) begin
        for (int i = 0; i < 4; i++) r_hist[i] <= '0;
      end
    end
  end

  assign period_out   = r_period;
  assign period_valid = r_valid;
  assign locked       = (r_state == S_TRACK);
  assign tap_seen     = r_tap;

endmodule

// File: tb/tb_tap_tempo_meter.sv
// Directed bench for tap_tempo_meter with small parameters; expected periods
// are hand-computed averages of the last four accepted intervals.
module tb_tap_tempo_meter;
  localparam int CNT_W = 16;

  logic             clk_rx = 1'b0;
  logic             nrst   = 1'b0;
  logic             tap_in = 1'b0;
  logic [CNT_W-1:0] period_out;
  logic             period_valid;
  logic             locked;
  logic             tap_seen;

  int total = 0;
  int bad   = 0;
  int ts_cnt = 0;
  int pv_cnt = 0;
  int pv_orphan = 0;
  logic prev_ts = 1'b0;

  int e_fall[4] = '{350, 300, 250, 200};
  int e_rise[3] = '{250, 300, 350};

  tap_tempo_meter #(
    .CNT_W(CNT_W), .DEBOUNCE(4), .MIN_PERIOD(100),
    .MAX_PERIOD(1000), .DEFAULT_PERIOD(500)
  ) dut (
    .clk_rx(clk_rx), .nrst(nrst), .tap_in(tap_in),
    .period_out(period_out), .period_valid(period_valid),
    .locked(locked), .tap_seen(tap_seen)
  );

  always #5 clk_rx = ~clk_rx;

  // period_valid must follow a tap_seen by exactly one cycle
  always @(negedge clk_rx) begin
    if (nrst) begin
      if (tap_seen) ts_cnt++;
      if (period_valid) begin
        pv_cnt++;
        if (!prev_ts) pv_orphan++;
      end
    end
    prev_ts = tap_seen;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int ets, input int epv,
                         input int elk, input int eper);
    chk({tag, ".tap_seen_cnt"}, ts_cnt, ets);
    chk({tag, ".valid_cnt"}, pv_cnt, epv);
    chk({tag, ".locked"}, int'(locked), elk);
    chk({tag, ".period"}, int'(period_out), eper);
  endtask

  task automatic drive(input logic v, input int n);
    tap_in = v;
    repeat (n) @(negedge clk_rx);
  endtask

  // rising edge lands exactly gap cycles after the previous press's rising edge
  task automatic tap(input int gap);
    drive(1'b0, gap - 20);
    drive(1'b1, 20);
  endtask

  initial begin
    nrst = 1'b0;
    repeat (3) @(negedge clk_rx);
    nrst = 1'b1;
    repeat (50) @(negedge clk_rx);
    chk_all("idle", 0, 0, 0, 500);

    tap(50);
    chk_all("clean_t1", 1, 0, 0, 500);
    tap(400);
    chk_all("clean_t2", 2, 1, 1, 400);
    for (int k = 3; k <= 5; k++) begin
      tap(400);
      chk_all("clean_tn", k, k - 1, 1, 400);
    end

    for (int i = 0; i < 4; i++) begin
      tap(200);
      chk_all("fall200", 6 + i, 5 + i, 1, e_fall[i]);
    end
    for (int i = 0; i < 3; i++) begin
      tap(400);
      chk_all("rise400", 10 + i, 9 + i, 1, e_rise[i]);
    end
    tap(401);
    chk_all("trunc", 13, 12, 1, 400);

    drive(1'b0, 10);
    drive(1'b1, 2);
    drive(1'b0, 10);
    drive(1'b1, 3);
    drive(1'b0, 10);
    chk_all("bounce", 13, 12, 1, 400);
    drive(1'b0, 5);
    drive(1'b1, 20);
    chk_all("short", 14, 12, 1, 400);
    tap(340);
    chk_all("after_short", 15, 13, 1, 400);

    tap(100);
    chk_all("min_iv", 16, 14, 1, 325);
    tap(1000);
    chk_all("max_iv", 17, 15, 1, 475);
    tap(1001);
    chk_all("timeout", 18, 15, 0, 475);
    tap(300);
    chk_all("relock", 19, 16, 1, 300);

    repeat (50) @(negedge clk_rx);
    nrst = 1'b0;
    @(negedge clk_rx);
    nrst = 1'b1;
    @(negedge clk_rx);
    chk("rst.period", int'(period_out), 500);
    chk("rst.locked", int'(locked), 0);
    tap(50);
    chk_all("rst_t1", 20, 16, 0, 500);
    tap(300);
    chk_all("rst_t2", 21, 17, 1, 300);

    chk("valid_latency", pv_orphan, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
